// File: rtl/axis_fifo_flags_if.sv
// axis_fifo_flags_if -- one AXI-stream link (payload, valid, ready) used for
// both the producer side and the consumer side of axis_fifo_flags.
// The producer drives master, the consumer drives slave.
// Optional feature macro: AXIS_FIFO_PACKET_EN adds the end-of-packet bit 'last'.
interface axis_fifo_flags_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
`ifdef AXIS_FIFO_PACKET_EN
  logic                  last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
`else

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
`endif

endinterface

// File: rtl/axis_fifo_flags.sv
// axis_fifo_flags -- single-clock AXI-stream FIFO with a registered output,
// an occupancy count and programmable almost-full / almost-empty flags.
//
// Storage is a RAM with a registered read; the read register doubles as the
// output register, so total capacity is DEPTH = 2**ADDR_WIDTH words counting
// the word parked in the output register.
//
// Optional feature macro: AXIS_FIFO_PACKET_EN
//   When defined, a 'last' bit travels with every word and the read side holds
//   words back until a complete packet sits in the RAM (store-and-forward).
//   A packet larger than the RAM is released cut-through once the RAM fills,
//   so the FIFO can never deadlock.
module axis_fifo_flags #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                clock,
  input  logic                resetn,
  axis_fifo_flags_if.slave    istream,
  axis_fifo_flags_if.master   ostream,
  output logic [ADDR_WIDTH:0] count,
  output logic                almost_full,
  output logic                almost_empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef AXIS_FIFO_PACKET_EN
  localparam int RAM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int RAM_WIDTH = DATA_WIDTH;
`endif

  // Level constants, all at the pointer/level width
  localparam logic [ADDR_WIDTH:0] LVL_ZERO   = {(ADDR_WIDTH + 1){1'b0}};
  localparam logic [ADDR_WIDTH:0] LVL_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LVL_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LVL_AFULL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] LVL_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  // Storage
  logic [RAM_WIDTH-1:0]  mem_r [DEPTH];

  // Registered state
  logic [ADDR_WIDTH:0]   waddr_r;
  logic [ADDR_WIDTH:0]   raddr_r;
  logic [ADDR_WIDTH:0]   size_r;      // words held in the RAM only
  logic [ADDR_WIDTH:0]   count_r;     // RAM plus output register
  logic                  ovalid_r;
  logic [DATA_WIDTH-1:0] odata_r;

  // Next-state values
  logic [ADDR_WIDTH:0]   waddr_next_s;
  logic [ADDR_WIDTH:0]   raddr_next_s;
  logic [ADDR_WIDTH:0]   size_next_s;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic                  ovalid_next_s;
  logic [DATA_WIDTH-1:0] odata_next_s;

  // Handshake decode
  logic                  iready_s;
  logic                  wen_s;
  logic                  pop_s;
  logic                  ren_s;
  logic                  ren_gate_s;
  logic [RAM_WIDTH-1:0]  wword_s;
  logic [RAM_WIDTH-1:0]  rword_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Ready is decoded from the registered count only: a pop while full does not
  // open the input in the same cycle, which keeps oready out of iready's cone.
  assign iready_s = (count_r != LVL_FULL);

  // RAM read data: the word at the read pointer, captured into odata on ren
  assign rword_s = mem_r[raddr_r[ADDR_WIDTH-1:0]];

`ifdef AXIS_FIFO_PACKET_EN
  logic [ADDR_WIDTH:0] pkts_r;        // complete packets still in the RAM
  logic [ADDR_WIDTH:0] pkts_next_s;
  logic                olast_r;
  logic                olast_next_s;
  logic                rlast_s;
  logic                wlast_s;

  assign wword_s = {istream.last, istream.data};
  assign rdata_s = rword_s[DATA_WIDTH-1:0];
  assign rlast_s = rword_s[DATA_WIDTH];
  assign wlast_s = wen_s && istream.last;

  // Hold reads until a whole packet is buffered, unless the RAM is full with
  // an oversize packet -- then release cut-through instead of deadlocking.
  assign ren_gate_s = (pkts_r != LVL_ZERO) || (size_r == LVL_FULL);

  // Packet counter and last-bit next state
  always_comb begin
    pkts_next_s  = pkts_r;
    olast_next_s = olast_r;
    case ({wlast_s, ren_s && rlast_s})
      2'b10:   pkts_next_s = pkts_r + LVL_ONE;
      2'b01:   pkts_next_s = pkts_r - LVL_ONE;
      default: pkts_next_s = pkts_r;
    endcase
    olast_next_s = ren_s ? rlast_s : olast_r;
  end

  // Packet counter and output last register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkts_r  <= LVL_ZERO;
      olast_r <= 1'b0;
    end else begin
      pkts_r  <= pkts_next_s;
      olast_r <= olast_next_s;
    end
  end

  assign ostream.last = olast_r;
`else
  assign wword_s    = istream.data;
  assign rdata_s    = rword_s;
  assign ren_gate_s = 1'b1;
`endif

  // Handshake decode: write on an accepted input beat, pop on an accepted
  // output beat, and refill the output register whenever it is free or leaving.
  always_comb begin
    wen_s = istream.valid && iready_s;
    pop_s = ovalid_r && ostream.ready;
    ren_s = (size_r != LVL_ZERO) && (!ovalid_r || ostream.ready) && ren_gate_s;
  end

  // Next-state for pointers, levels and the output register
  always_comb begin
    waddr_next_s  = wen_s ? (waddr_r + LVL_ONE) : waddr_r;
    raddr_next_s  = ren_s ? (raddr_r + LVL_ONE) : raddr_r;
    size_next_s   = size_r;
    count_next_s  = count_r;
    case ({wen_s, ren_s})
      2'b10:   size_next_s = size_r + LVL_ONE;
      2'b01:   size_next_s = size_r - LVL_ONE;
      default: size_next_s = size_r;
    endcase
    case ({wen_s, pop_s})
      2'b10:   count_next_s = count_r + LVL_ONE;
      2'b01:   count_next_s = count_r - LVL_ONE;
      default: count_next_s = count_r;
    endcase
    // A word stays presented until taken; a fresh read always presents one.
    ovalid_next_s = ren_s || (ovalid_r && !ostream.ready);
    odata_next_s  = ren_s ? rdata_s : odata_r;
  end

  // RAM write port; storage is not reset, only the pointers are
  always_ff @(posedge clock) begin
    if (wen_s) begin
      mem_r[waddr_r[ADDR_WIDTH-1:0]] <= wword_s;
    end
  end

  // Pointer, level and output registers; everything clears at once on resetn
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      waddr_r  <= LVL_ZERO;
      raddr_r  <= LVL_ZERO;
      size_r   <= LVL_ZERO;
      count_r  <= LVL_ZERO;
      ovalid_r <= 1'b0;
      odata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      waddr_r  <= waddr_next_s;
      raddr_r  <= raddr_next_s;
      size_r   <= size_next_s;
      count_r  <= count_next_s;
      ovalid_r <= ovalid_next_s;
      odata_r  <= odata_next_s;
    end
  end

  assign istream.ready = iready_s;
  assign ostream.valid = ovalid_r;
  assign ostream.data  = odata_r;
  assign count         = count_r;

  // Level flags straight from the registered count
  assign almost_full  = (count_r >= LVL_AFULL);
  assign almost_empty = (count_r <= LVL_AEMPTY);

endmodule
